// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: opcode encodings, FSM states and the status flag bundle.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_SRA = 4'd8,
    OP_SLT = 4'd9,
    OP_MUL = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle of the sequential ALU; master drives operands, slave is the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, err
  );
endinterface

// File: rtl/alu_seq_comb.sv
// Single-cycle combinational datapath for opcodes 0-9 with status flags; every other opcode
// (including MUL, which the parent handles) reports illegal with a zero result.
module alu_seq_comb
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output alu_flags_t       flags,
  output logic             illegal
);

  logic        [WIDTH:0]   sum;
  logic        [WIDTH:0]   diff;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic        [SHW-1:0]   shamt;
  logic                    carry;
  logic                    ovf;

  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};
  assign a_s   = a;
  assign b_s   = b;
  assign shamt = b[SHW-1:0];

  always_comb begin
    result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    illegal = 1'b0;
    case (alu_op_e'(op))
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
        ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // diff[WIDTH] is the borrow out of the unsigned subtraction
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
        ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL:  result = a << shamt;
      OP_SHR:  result = a >> shamt;
      OP_SRA:  result = a_s >>> shamt;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      default: illegal = 1'b1;
    endcase
  end

  assign flags = '{z: (result == '0), n: result[WIDTH-1], c: carry, v: ovf};

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: IDLE/EXEC/DONE FSM, registered result and flags with backpressure.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier for opcode 10.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q;
  alu_flags_t       flags_q;
  logic             err_q;
  logic             accept;
  logic             mul_start;
  logic             mul_last;
  logic [WIDTH-1:0] comb_res;
  alu_flags_t       comb_flags;
  logic             comb_illegal;

  alu_seq_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
    .op      (bus.op),
    .a       (bus.a),
    .b       (bus.b),
    .result  (comb_res),
    .flags   (comb_flags),
    .illegal (comb_illegal)
  );

`ifdef ALU_SEQ_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] acc_step;

  // One step: add the multiplicand into the upper half when the current B bit is set, then shift right.
  assign addend   = mplier_q[0] ? mcand_q : '0;
  assign step_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign acc_step = {step_sum, acc_q[WIDTH-1:1]};
  assign mul_last = (state_q == ST_EXEC) && (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (mul_start) begin
      cnt_q <= '0;
    end else if (state_q == ST_EXEC) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (mul_start) begin
      acc_q    <= '0;
      mcand_q  <= bus.a;
      mplier_q <= bus.b;
    end else if (state_q == ST_EXEC) begin
      acc_q    <= acc_step;
      mplier_q <= mplier_q >> 1;
    end
  end
`else
  assign mul_last = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    mul_start = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = ST_DONE;
`ifdef ALU_SEQ_MUL_EN
          if (alu_op_e'(bus.op) == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_EXEC;
          end
`endif
        end
      end
      ST_EXEC: begin
`ifdef ALU_SEQ_MUL_EN
        if (mul_last) state_d = ST_DONE;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (bus.out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && !mul_start) begin
        result_q <= comb_res;
        flags_q  <= comb_flags;
        err_q    <= comb_illegal;
      end
`ifdef ALU_SEQ_MUL_EN
      else if (mul_last) begin
        result_q <= acc_step[WIDTH-1:0];
        flags_q  <= '{z: (acc_step[WIDTH-1:0] == '0), n: acc_step[WIDTH-1],
                      c: |acc_step[2*WIDTH-1:WIDTH], v: 1'b0};
        err_q    <= 1'b0;
      end
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.flag_z    = flags_q.z;
  assign bus.flag_n    = flags_q.n;
  assign bus.flag_c    = flags_q.c;
  assign bus.flag_v    = flags_q.v;
  assign bus.err       = err_q;

endmodule
